bcd_mod_counter_seg: RTL
========================

BCD_MOD_COUNTER_SEG -- requirements
Module: bcd_mod_counter_seg

Interface
REQ-001 The module SHALL have parameter MODULUS, default 24, meaning count range 0..MODULUS-1; legal values are 2..100.
REQ-002 The module SHALL have parameter DIV_N, default 10, meaning clk_in cycles per count tick; legal values are >=1.
REQ-003 The module SHALL have port clk_in, input, 1 bit: the single clock; all state SHALL be updated on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port en, input, 1 bit: count enable, sampled only on tick cycles.
REQ-006 The module SHALL have port up_dn, input, 1 bit: 1 = count up, 0 = count down.
REQ-007 The module SHALL have port load, input, 1 bit: synchronous load strobe.
REQ-008 The module SHALL have port load_tens, input, 4 bits: BCD tens digit to load.
REQ-009 The module SHALL have port load_ones, input, 4 bits: BCD ones digit to load.
REQ-010 The module SHALL have port cnt_tens, output, 4 bits: current BCD tens digit.
REQ-011 The module SHALL have port cnt_ones, output, 4 bits: current BCD ones digit.
REQ-012 The module SHALL have port seg_data1, output, 8 bits: 7-seg pattern for the ones digit.
REQ-013 The module SHALL have port seg_data2, output, 8 bits: 7-seg pattern for the tens digit.
REQ-014 The module SHALL have port carry, output, 1 bit: one-cycle pulse on wrap.
REQ-015 The module SHALL have port load_err, output, 1 bit: one-cycle pulse on a rejected load.

Function
REQ-016 The prescaler SHALL be a free-running counter 0..DIV_N-1 that asserts an internal tick for one clk_in cycle when it reaches DIV_N-1, then wraps to 0; with DIV_N=1, tick SHALL be high every cycle; no derived clock SHALL be used.
REQ-017 On a tick with en=1 and up_dn=1, the count SHALL increment in BCD (ones 9 -> 0 with tens+1); at MODULUS-1 it SHALL wrap to 00.
REQ-018 On a tick with en=1 and up_dn=0, the count SHALL decrement in BCD (ones 0 -> 9 with tens-1); at 00 it SHALL wrap to MODULUS-1.
REQ-019 carry SHALL be 1 for exactly the cycle after a wrap in either direction, and 0 otherwise.
REQ-020 The count SHALL hold when there is no tick or en=0.
REQ-021 If load=1 and 10*load_tens+load_ones < MODULUS with both digits <=9, the count SHALL take the loaded value on the next edge.
REQ-022 An otherwise legal load SHALL be rejected when load_tens >9, load_ones >9, or the value is >= MODULUS; in that case the count SHALL hold and load_err SHALL pulse for one cycle.
REQ-023 When load coincides with a counting tick, load SHALL win; no count step and no carry SHALL occur, and the prescaler SHALL be unaffected.
REQ-024 A rejected load coinciding with a tick SHALL also suppress that count step.
REQ-025 seg_data1 and seg_data2 SHALL be combinational decodes of cnt_ones and cnt_tens, with zero added latency.
REQ-026 The segment bit order SHALL be {a,b,c,d,e,f,g,dp}, active-high, with dp=0.
REQ-027 The digit encodings SHALL be: 0=FC, 1=60, 2=DA, 3=F2, 4=66, 5=B6, 6=BE, 7=E0, 8=FE, 9=F6.
REQ-028 Any digit value >9 SHALL decode to 8'h02 (dp only); this is unreachable in normal operation.
REQ-029 The count SHALL always be a valid BCD value < MODULUS.

Reset
REQ-030 rst=0 SHALL immediately and asynchronously force prescaler=0, cnt_tens=0, cnt_ones=0, carry=0, and load_err=0, so that seg_data1=seg_data2=8'hFC.
REQ-031 Reset asserted mid-count or mid-load SHALL abandon the operation.
REQ-032 After rst deasserts, the first tick SHALL occur DIV_N edges later.

Verification
REQ-033 Defaults, en=1, up_dn=1, run 240 clk_in cycles -> count steps 00..23 once per 10 cycles, then wraps to 00 with one carry pulse; seg_data2/seg_data1 = 60/F2 at count 13.
REQ-034 MODULUS=60, load 00, up_dn=0, one tick -> count=59, carry pulses once, seg_data2=B6, seg_data1=F6.
REQ-035 Defaults, load 2/5 -> load_err pulses and count is unchanged; load 1/A -> load_err pulses; load 2/3 -> count=23 with no load_err.
REQ-036 load 0/7 on the same cycle as a tick while counting up from 12 -> count=07 with no step and no carry.
REQ-037 en=0 across 50 ticks -> count constant and carry=0.
REQ-038 DIV_N=1, assert rst low asynchronously between edges at count 17 -> outputs read 00/FC/FC before the next edge; after release, counting resumes with 01 on the first edge.

Source files
------------

// File: rtl/bcd_mod_counter_seg.sv
// rtl/bcd_mod_counter_seg.sv - prescaled BCD up/down modulo counter with load and 7-segment decode
module bcd_mod_counter_seg #(
    parameter int MODULUS = 24,
    parameter int DIV_N   = 10
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       en,
    input  logic       up_dn,
    input  logic       load,
    input  logic [3:0] load_tens,
    input  logic [3:0] load_ones,
    output logic [3:0] cnt_tens,
    output logic [3:0] cnt_ones,
    output logic [7:0] seg_data1,
    output logic [7:0] seg_data2,
    output logic       carry,
    output logic       load_err
);

    localparam int PW = (DIV_N > 1) ? $clog2(DIV_N) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(DIV_N - 1);
    localparam logic [3:0] MAX_TENS = 4'((MODULUS - 1) / 10);
    localparam logic [3:0] MAX_ONES = 4'((MODULUS - 1) % 10);
    localparam logic [7:0] MOD_VAL  = 8'(MODULUS);

    logic [PW-1:0] pre;
    logic          tick;
    logic [7:0]    load_val;
    logic          load_ok;
    logic          at_max;
    logic          at_zero;

    assign tick     = (pre == PRE_MAX);
    // Widened to 8 bits so out-of-range digits (up to 15) cannot alias into range.
    assign load_val = ({4'd0, load_tens} * 8'd10) + {4'd0, load_ones};
    assign load_ok  = (load_tens <= 4'd9) && (load_ones <= 4'd9) && (load_val < MOD_VAL);
    assign at_max   = (cnt_tens == MAX_TENS) && (cnt_ones == MAX_ONES);
    assign at_zero  = (cnt_tens == 4'd0) && (cnt_ones == 4'd0);

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            pre      <= '0;
            cnt_tens <= 4'd0;
            cnt_ones <= 4'd0;
            carry    <= 1'b0;
            load_err <= 1'b0;
        end else begin
            pre      <= tick ? '0 : pre + PW'(1);
            carry    <= 1'b0;
            load_err <= 1'b0;
            // A load, accepted or rejected, always takes precedence over a count step.
            if (load) begin
                if (load_ok) begin
                    cnt_tens <= load_tens;
                    cnt_ones <= load_ones;
                end else begin
                    load_err <= 1'b1;
                end
            end else if (tick && en) begin
                if (up_dn) begin
                    if (at_max) begin
                        cnt_tens <= 4'd0;
                        cnt_ones <= 4'd0;
                        carry    <= 1'b1;
                    end else if (cnt_ones == 4'd9) begin
                        cnt_ones <= 4'd0;
                        cnt_tens <= cnt_tens + 4'd1;
                    end else begin
                        cnt_ones <= cnt_ones + 4'd1;
                    end
                end else begin
                    if (at_zero) begin
                        cnt_tens <= MAX_TENS;
                        cnt_ones <= MAX_ONES;
                        carry    <= 1'b1;
                    end else if (cnt_ones == 4'd0) begin
                        cnt_ones <= 4'd9;
                        cnt_tens <= cnt_tens - 4'd1;
                    end else begin
                        cnt_ones <= cnt_ones - 4'd1;
                    end
                end
            end
        end
    end

    // Segment order {a,b,c,d,e,f,g,dp}; non-BCD digits show only the decimal point.
    function automatic logic [7:0] seg_decode(input logic [3:0] digit);
        case (digit)
            4'd0:    seg_decode = 8'hFC;
            4'd1:    seg_decode = 8'h60;
            4'd2:    seg_decode = 8'hDA;
            4'd3:    seg_decode = 8'hF2;
            4'd4:    seg_decode = 8'h66;
            4'd5:    seg_decode = 8'hB6;
            4'd6:    seg_decode = 8'hBE;
            4'd7:    seg_decode = 8'hE0;
            4'd8:    seg_decode = 8'hFE;
            4'd9:    seg_decode = 8'hF6;
            default: seg_decode = 8'h02;
        endcase
    endfunction

    assign seg_data1 = seg_decode(cnt_ones);
    assign seg_data2 = seg_decode(cnt_tens);

endmodule
